// File: rtl/muldiv4_seq_ctrl_if.sv
// Operand/opcode request and result bundle for the muldiv4 sequencer.
// Master drives start/op/a/b; slave returns busy/done/result/div_by_zero.
interface muldiv4_seq_ctrl_if #(
    parameter int WIDTH = 4
);
    logic                   start;
    logic                   op;
    logic [WIDTH-1:0]       a;
    logic [WIDTH-1:0]       b;
    logic                   busy;
    logic                   done;
    logic [2*WIDTH-1:0]     result;
    logic                   div_by_zero;

    modport master (
        output start, op, a, b,
        input  busy, done, result, div_by_zero
    );

    modport slave (
        input  start, op, a, b,
        output busy, done, result, div_by_zero
    );
endinterface

// File: rtl/muldiv4_seq_ctrl.sv
// Sequential unsigned shift-add multiply / restoring divide, one bit per clock.
// Latency: done in the cycle after edge WIDTH (after E0 for divide-by-zero).
// Backpressure: start is ignored while busy, including the done cycle.
module muldiv4_seq_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    muldiv4_seq_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic                 op_q;
    logic [WIDTH-1:0]     oper;   // multiplicand or divisor, constant during RUN
    logic [WIDTH-1:0]     sreg;   // multiplier, or dividend shifting out / quotient shifting in
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     rem;

    logic [WIDTH:0]       mul_sum;
    logic [2*WIDTH-1:0]   mul_acc_nx;
    logic [WIDTH-1:0]     mul_sreg_nx;
    logic [WIDTH:0]       div_trial;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_rem_nx;
    logic [WIDTH-1:0]     div_sreg_nx;

    always_comb begin
        mul_sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (sreg[0] ? {1'b0, oper} : '0);
        // the carry out of the add lands in the top bit after the right shift
        mul_acc_nx  = {mul_sum, acc[WIDTH-1:1]};
        mul_sreg_nx = {acc[0], sreg[WIDTH-1:1]};

        // trial keeps rem's MSB so the compare is done at WIDTH+1 bits
        div_trial   = {rem, sreg[WIDTH-1]};
        div_ge      = (div_trial >= {1'b0, oper});
        div_rem_nx  = div_ge ? (div_trial[WIDTH-1:0] - oper) : div_trial[WIDTH-1:0];
        div_sreg_nx = {sreg[WIDTH-2:0], div_ge};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            op_q            <= 1'b0;
            oper            <= '0;
            sreg            <= '0;
            acc             <= '0;
            rem             <= '0;
            bus.busy        <= 1'b0;
            bus.done        <= 1'b0;
            bus.result      <= '0;
            bus.div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        op_q     <= bus.op;
                        oper     <= bus.op ? bus.b : bus.a;
                        sreg     <= bus.op ? bus.a : bus.b;
                        acc      <= '0;
                        rem      <= '0;
                        cnt      <= CW'(WIDTH);
                        bus.busy <= 1'b1;
                        if (bus.op && (bus.b == '0)) begin
                            state           <= DONE;
                            bus.done        <= 1'b1;
                            bus.result      <= {bus.a, {WIDTH{1'b1}}};
                            bus.div_by_zero <= 1'b1;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt <= cnt - CW'(1);
                    if (op_q) begin
                        rem  <= div_rem_nx;
                        sreg <= div_sreg_nx;
                    end else begin
                        acc  <= mul_acc_nx;
                        sreg <= mul_sreg_nx;
                    end
                    if (cnt == CW'(1)) begin
                        state           <= DONE;
                        bus.done        <= 1'b1;
                        bus.result      <= op_q ? {div_rem_nx, div_sreg_nx} : mul_acc_nx;
                        bus.div_by_zero <= 1'b0;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.done <= 1'b0;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv4_seq_ctrl.sv
// Scoreboard bench for muldiv4_seq_ctrl: expected results queued at start, checked at done.
module tb_muldiv4_seq_ctrl;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    muldiv4_seq_ctrl_if #(.WIDTH(4)) bus ();

    muldiv4_seq_ctrl #(.WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    typedef struct packed {
        logic [7:0] res;
        logic       dbz;
    } exp_t;

    exp_t       sb_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic [7:0] prev_res = 8'h00;
    logic       prev_dbz = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic o, input logic [3:0] x, input logic [3:0] y);
        exp_t e;
        if (o) begin
            if (y == 4'd0) begin
                e.res = {x, 4'hF};
                e.dbz = 1'b1;
            end else begin
                e.res = {x % y, x / y};
                e.dbz = 1'b0;
            end
        end else begin
            e.res = {4'b0, x} * {4'b0, y};
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Monitor: pops the scoreboard on done, otherwise outputs must hold the last result.
    always @(negedge clk) begin
        if (rst) begin
            prev_res = 8'h00;
            prev_dbz = 1'b0;
        end else if (bus.done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'(bus.done), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_result", 32'(bus.result), 32'(e.res));
                chk("sb_dbz", 32'(bus.div_by_zero), 32'(e.dbz));
                prev_res = e.res;
                prev_dbz = e.dbz;
            end
        end else begin
            chk("hold_result", 32'(bus.result), 32'(prev_res));
            chk("hold_dbz", 32'(bus.div_by_zero), 32'(prev_dbz));
        end
    end

    // Called #1 after a rising edge with the DUT idle; returns likewise.
    task automatic do_op(input logic o, input logic [3:0] x, input logic [3:0] y, input bit scramble);
        int n;
        int lat;
        lat = (o && (y == 4'd0)) ? 0 : 4;
        bus.start = 1'b1;
        bus.op    = o;
        bus.a     = x;
        bus.b     = y;
        sb_q.push_back(model(o, x, y));
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("busy_e0", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 20) begin
            if (scramble) begin
                bus.op = 1'($urandom);
                bus.a  = 4'($urandom);
                bus.b  = 4'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 32'(n), 32'(lat));
        @(posedge clk); #1;
        chk("done_clr", 32'(bus.done), 32'd0);
        chk("busy_clr", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int n;
        rst       = 1'b0;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.a     = 4'd0;
        bus.b     = 4'd0;
        #2 rst = 1'b1;
        #1;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_dbz", 32'(bus.div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        do_op(1'b0, 4'd15, 4'd15, 1'b0);
        do_op(1'b1, 4'd13, 4'd4, 1'b0);
        do_op(1'b1, 4'd3, 4'd7, 1'b0);
        do_op(1'b1, 4'd9, 4'd0, 1'b0);
        do_op(1'b0, 4'd2, 4'd3, 1'b0);

        // start held high through RUN and DONE with changing operands
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 4'd3;
        bus.b     = 4'd5;
        sb_q.push_back(model(1'b0, 4'd3, 4'd5));
        @(posedge clk); #1;
        chk("hold_busy_e0", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 20) begin
            bus.op = 1'($urandom);
            bus.a  = 4'($urandom);
            bus.b  = 4'($urandom);
            @(posedge clk); #1;
            n++;
        end
        chk("hold_latency", 32'(n), 32'd4);
        bus.a = 4'($urandom);
        @(posedge clk); #1;
        chk("start_ignored_in_done", 32'(bus.busy), 32'd0);
        bus.op = 1'b0;
        bus.a  = 4'd4;
        bus.b  = 4'd4;
        sb_q.push_back(model(1'b0, 4'd4, 4'd4));
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("b2b_accept", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.done && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("b2b_latency", 32'(n), 32'd4);
        @(posedge clk); #1;

        // asynchronous reset in the middle of the second iteration
        bus.start = 1'b1;
        bus.op    = 1'b0;
        bus.a     = 4'd7;
        bus.b     = 4'd7;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy), 32'd0);
        chk("arst_done", 32'(bus.done), 32'd0);
        chk("arst_result", 32'(bus.result), 32'd0);
        chk("arst_dbz", 32'(bus.div_by_zero), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            chk("no_late_done", 32'(bus.done), 32'd0);
        end
        do_op(1'b0, 4'd5, 4'd3, 1'b0);

        do_op(1'b0, 4'd7, 4'd6, 1'b1);

        for (int i = 0; i < 16; i++) begin
            do_op(1'($urandom), 4'($urandom), 4'($urandom), 1'($urandom));
        end

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
